// File: rtl/food_manager.sv
// Food cell owner for the snake playfield: detects eats, stretches the inc_len
// pulse, and places new food by rejection-sampling a free-running LFSR.
module food_manager #(
   parameter int          GRID_W    = 40,
   parameter int          GRID_H    = 30,
   parameter int          X_W       = 6,
   parameter int          Y_W       = 5,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          INC_PULSE = 4,
   parameter int          MAX_TRIES = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           game_run,
   input  logic           head_valid,
   input  logic [X_W-1:0] head_x,
   input  logic [Y_W-1:0] head_y,
   output logic [X_W-1:0] food_x,
   output logic [Y_W-1:0] food_y,
   output logic           food_valid,
   output logic           inc_len
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PLACE  = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;
   localparam logic [1:0] EATEN  = 2'd3;

   localparam int TRY_W   = $clog2(MAX_TRIES + 1);
   localparam int PULSE_W = $clog2(INC_PULSE + 1);

   localparam logic [X_W-1:0]     X_MAX      = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0]     Y_MAX      = Y_W'(GRID_H - 1);
   localparam logic [TRY_W-1:0]   TRY_LAST   = TRY_W'(MAX_TRIES - 1);
   localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(INC_PULSE - 1);

   logic [1:0]         state;
   logic [15:0]        lfsr;
   logic [TRY_W-1:0]   try_cnt;
   logic [PULSE_W-1:0] pulse_cnt;

   logic           lfsr_fb;
   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   logic           cand_ok;
   logic           head_on_food;
   logic           head_at_origin;

   // taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   assign cx = lfsr[X_W-1:0];
   assign cy = lfsr[X_W+Y_W-1:X_W];

   assign cand_ok        = (cx <= X_MAX) && (cy <= Y_MAX) &&
                           !((cx == head_x) && (cy == head_y));
   assign head_on_food   = (head_x == food_x) && (head_y == food_y);
   assign head_at_origin = (head_x == '0) && (head_y == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         try_cnt    <= '0;
         pulse_cnt  <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         inc_len    <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         // game_run low wins over every state, truncating any pulse
         if (!game_run) begin
            state      <= IDLE;
            food_valid <= 1'b0;
            inc_len    <= 1'b0;
            try_cnt    <= '0;
            pulse_cnt  <= '0;
         end else begin
            case (state)
               IDLE: state <= PLACE;
               PLACE: begin
                  if (cand_ok) begin
                     food_x     <= cx;
                     food_y     <= cy;
                     food_valid <= 1'b1;
                     try_cnt    <= '0;
                     state      <= ACTIVE;
                  end else if (try_cnt == TRY_LAST) begin
                     // fallback keeps placement bounded; avoid landing on the head
                     food_x     <= head_at_origin ? X_MAX : '0;
                     food_y     <= head_at_origin ? Y_MAX : '0;
                     food_valid <= 1'b1;
                     try_cnt    <= '0;
                     state      <= ACTIVE;
                  end else begin
                     try_cnt <= try_cnt + 1'b1;
                  end
               end
               ACTIVE: begin
                  if (head_valid && head_on_food) begin
                     food_valid <= 1'b0;
                     inc_len    <= 1'b1;
                     pulse_cnt  <= PULSE_LOAD;
                     state      <= EATEN;
                  end
               end
               EATEN: begin
                  if (pulse_cnt != '0) begin
                     pulse_cnt <= pulse_cnt - 1'b1;
                  end else begin
                     inc_len <= 1'b0;
                     state   <= PLACE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_food_manager.sv
// Bench for food_manager: directed scenarios plus randomized traffic, every
// cycle compared against an event-level reference model of the food rules.
module tb_food_manager;

   localparam int P_IDLE   = 0;
   localparam int P_PLACE  = 1;
   localparam int P_ACTIVE = 2;
   localparam int P_EATEN  = 3;

   logic       clk;
   logic       reset;
   logic       game_run;
   logic       head_valid;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [5:0] food_x;
   logic [4:0] food_y;
   logic       food_valid;
   logic       inc_len;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [15:0] m_lfsr;
   int          m_ph;
   int          m_fx, m_fy;
   logic        m_fv, m_inc;
   int          m_rejects;
   int          m_age;
   bit          forced;
   logic [15:0] fval;

   int   rise_cnt;
   logic prev_inc;

   food_manager dut (
      .clk        (clk),
      .reset      (reset),
      .game_run   (game_run),
      .head_valid (head_valid),
      .head_x     (head_x),
      .head_y     (head_y),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .inc_len    (inc_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & 16'hB400)};
   endfunction

   task automatic model_place(input int x, input int y);
      m_fx = x;
      m_fy = y;
      m_fv = 1'b1;
      m_rejects = 0;
      m_ph = P_ACTIVE;
   endtask

   // applied once per rising edge, using the inputs held across that edge
   task automatic model_step();
      logic [15:0] cur;
      int cx, cy;
      if (!reset) begin
         m_lfsr = 16'hACE1;
         m_ph = P_IDLE;
         m_fx = 0;
         m_fy = 0;
         m_fv = 1'b0;
         m_inc = 1'b0;
         m_rejects = 0;
         m_age = 0;
         return;
      end
      cur = m_lfsr;
      m_lfsr = forced ? fval : lfsr_next(cur);
      cx = int'(cur[5:0]);
      cy = int'(cur[10:6]);
      if (!game_run) begin
         m_ph = P_IDLE;
         m_fv = 1'b0;
         m_inc = 1'b0;
         m_rejects = 0;
         return;
      end
      case (m_ph)
         P_IDLE: m_ph = P_PLACE;
         P_PLACE: begin
            if (cx < 40 && cy < 30 && !(cx == int'(head_x) && cy == int'(head_y)))
               model_place(cx, cy);
            else begin
               m_rejects++;
               if (m_rejects == 64) begin
                  if (head_x == 6'd0 && head_y == 5'd0) model_place(39, 29);
                  else model_place(0, 0);
               end
            end
         end
         P_ACTIVE: begin
            if (head_valid && int'(head_x) == m_fx && int'(head_y) == m_fy) begin
               m_fv = 1'b0;
               m_inc = 1'b1;
               m_age = 0;
               m_ph = P_EATEN;
            end
         end
         default: begin
            m_age++;
            if (m_age >= 4) begin
               m_inc = 1'b0;
               m_ph = P_PLACE;
            end
         end
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("food_valid", 32'(food_valid), 32'(m_fv));
      chk("inc_len", 32'(inc_len), 32'(m_inc));
      chk("food_x", 32'(food_x), 32'(m_fx));
      chk("food_y", 32'(food_y), 32'(m_fy));
      if (inc_len === 1'b1 && prev_inc !== 1'b1) rise_cnt++;
      prev_inc = inc_len;
   endtask

   task automatic strobe(input logic [5:0] x, input logic [4:0] y);
      head_x = x;
      head_y = y;
      head_valid = 1'b1;
      cyc();
      head_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int limit, output int n);
      n = 0;
      while (food_valid !== 1'b1 && n < limit) begin
         cyc();
         n++;
      end
      chk(tag, 32'(food_valid), 32'd1);
   endtask

   task automatic set_force(input logic [15:0] v);
      forced = 1'b1;
      fval = v;
      m_lfsr = v;
      force dut.lfsr = v;
   endtask

   task automatic clr_force();
      forced = 1'b0;
      release dut.lfsr;
   endtask

   initial begin
      int n;
      forced = 1'b0;
      fval = 16'h0;
      rise_cnt = 0;
      prev_inc = 1'b0;
      reset = 1'b0;
      game_run = 1'b0;
      head_valid = 1'b0;
      head_x = 6'd20;
      head_y = 5'd15;
      @(negedge clk);

      // reset held low with the game stopped
      repeat (3) cyc();
      chk("rst_food_valid", 32'(food_valid), 32'd0);
      chk("rst_inc_len", 32'(inc_len), 32'd0);
      chk("rst_food_xy", 32'({food_x, food_y}), 32'd0);
      reset = 1'b1;
      repeat (10) cyc();
      chk("idle_food_valid", 32'(food_valid), 32'd0);

      // first placement from the seeded LFSR
      game_run = 1'b1;
      wait_valid("place_timeout", 66, n);
      chk("place_x_range", 32'(int'(food_x) < 40), 32'd1);
      chk("place_y_range", 32'(int'(food_y) < 30), 32'd1);
      chk("place_not_head", 32'(food_x != head_x || food_y != head_y), 32'd1);

      // steer placement to (12,7)
      game_run = 1'b0;
      cyc();
      set_force(16'h01CC);
      head_x = 6'd0;
      head_y = 5'd0;
      game_run = 1'b1;
      wait_valid("steer_timeout", 10, n);
      clr_force();
      chk("steer_food_x", 32'(food_x), 32'd12);
      chk("steer_food_y", 32'(food_y), 32'd7);

      // near miss never eats
      rise_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (i % 3 == 0) strobe(6'd12, 5'd8);
         else cyc();
      end
      chk("miss_no_inc", 32'(rise_cnt), 32'd0);
      chk("miss_food_x", 32'(food_x), 32'd12);
      chk("miss_food_y", 32'(food_y), 32'd7);
      chk("miss_food_valid", 32'(food_valid), 32'd1);

      // eat at (12,7): four cycles high, then low
      strobe(6'd12, 5'd7);
      chk("eat_inc_1", 32'(inc_len), 32'd1);
      chk("eat_fv_cleared", 32'(food_valid), 32'd0);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         chk("eat_inc_hi", 32'(inc_len), 32'd1);
      end
      cyc();
      chk("eat_inc_5", 32'(inc_len), 32'd0);
      chk("eat_one_rise", 32'(rise_cnt), 32'd1);
      wait_valid("replace_timeout", 66, n);

      // game_run dropped mid-pulse truncates it
      rise_cnt = 0;
      strobe(6'(m_fx), 5'(m_fy));
      cyc();
      game_run = 1'b0;
      cyc();
      chk("trunc_inc", 32'(inc_len), 32'd0);
      repeat (6) cyc();
      chk("trunc_rises", 32'(rise_cnt), 32'd1);

      // all candidates out of range: fallback placement
      set_force(16'hFFFF);
      head_x = 6'd5;
      head_y = 5'd5;
      game_run = 1'b1;
      wait_valid("fallback_timeout", 80, n);
      chk("fallback_cycles", 32'(n), 32'd65);
      chk("fallback_xy00", 32'({food_x, food_y}), 32'd0);
      game_run = 1'b0;
      cyc();
      head_x = 6'd0;
      head_y = 5'd0;
      game_run = 1'b1;
      wait_valid("fallback2_timeout", 80, n);
      chk("fallback_x39", 32'(food_x), 32'd39);
      chk("fallback_y29", 32'(food_y), 32'd29);
      clr_force();

      // randomized traffic against the model
      reset = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 599) != 0);
         game_run = ($urandom_range(0, 149) != 0);
         head_valid = ($urandom_range(0, 2) == 0);
         if (m_ph == P_ACTIVE && $urandom_range(0, 2) == 0) begin
            head_x = 6'(m_fx);
            head_y = 5'(m_fy);
         end else begin
            head_x = 6'($urandom_range(0, 45));
            head_y = 5'($urandom_range(0, 31));
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
